// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU command encodings and register-zero index.
package cpu_pkg;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int CW = 3;

    typedef enum logic [CW-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SGT = 3'b011,
        ALU_SRL = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_EQ  = 3'b111
    } alu_cmd_e;

    localparam logic [RW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand bypass select: EX/MEM result beats MEM/WB data beats stored regfile data.
// Register r0 always reads as zero and is never bypassed.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int RW = cpu_pkg::RW
) (
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] stored_data,
    input  logic          exmem_wr_en,
    input  logic [RW-1:0] exmem_rd_addr,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_wr_en,
    input  logic [RW-1:0] memwb_rd_addr,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data
);

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        data = stored_data;
        if (addr == REG_ZERO) begin
            data = '0;
        end else if (exmem_wr_en && (exmem_rd_addr == addr)) begin
            data = exmem_res;
        end else if (memwb_wr_en && (memwb_rd_addr == addr)) begin
            data = memwb_data;
        end
    end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand bypass
// and load-use hazard detection.
module idex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int RW = cpu_pkg::RW,
    parameter int CW = cpu_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic [CW-1:0] id_cmd,
    input  logic [RW-1:0] id_rd_addr,
    input  logic          id_wr_en,
    input  logic          id_is_load,
    input  logic          exmem_wr_en,
    input  logic [RW-1:0] exmem_rd_addr,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_wr_en,
    input  logic [RW-1:0] memwb_rd_addr,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [CW-1:0] alu_cmd,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd_addr,
    output logic          ex_wr_en,
    output logic          ex_is_load,
    output logic          load_use_hazard
);

    logic          valid_q;
    logic          wr_en_q;
    logic          is_load_q;
    logic [RW-1:0] rd_addr_q;
    logic [CW-1:0] cmd_q;
    logic [RW-1:0] rs_addr_q;
    logic [RW-1:0] rt_addr_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic          use_imm_q;

    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;
    logic          bubble;

    operand_fwd_mux #(.DW(DW), .RW(RW)) u_rs_fwd (
        .addr          (rs_addr_q),
        .stored_data   (rs_data_q),
        .exmem_wr_en   (exmem_wr_en),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_res     (exmem_res),
        .memwb_wr_en   (memwb_wr_en),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_data    (memwb_data),
        .data          (rs_fwd)
    );

    operand_fwd_mux #(.DW(DW), .RW(RW)) u_rt_fwd (
        .addr          (rt_addr_q),
        .stored_data   (rt_data_q),
        .exmem_wr_en   (exmem_wr_en),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_res     (exmem_res),
        .memwb_wr_en   (memwb_wr_en),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_data    (memwb_data),
        .data          (rt_fwd)
    );

    // ID reads the register a load in EX is still fetching; an immediate OP2 ignores rt.
    assign load_use_hazard = id_valid && valid_q && is_load_q && (rd_addr_q != REG_ZERO) &&
                             ((id_rs_addr == rd_addr_q) ||
                              (!id_use_imm && (id_rt_addr == rd_addr_q)));

    // Only reached when not stalled, or when flush overrides the stall.
    assign bubble = flush || load_use_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (!rst_n) begin
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            rd_addr_q <= '0;
            cmd_q     <= ALU_ADD;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (stall && !flush) begin
            // Latch the bypassed value so a producer retiring mid-stall is not lost.
            rs_data_q <= rs_fwd;
            rt_data_q <= rt_fwd;
        end else begin
            valid_q   <= id_valid && !bubble;
            wr_en_q   <= id_valid && id_wr_en && !bubble;
            is_load_q <= id_valid && id_is_load && !bubble;
            rd_addr_q <= id_rd_addr;
            cmd_q     <= id_cmd;
            rs_addr_q <= id_rs_addr;
            rt_addr_q <= id_rt_addr;
            rs_data_q <= (id_rs_addr == REG_ZERO) ? '0 : id_rs_data;
            rt_data_q <= (id_rt_addr == REG_ZERO) ? '0 : id_rt_data;
            imm_q     <= id_imm;
            use_imm_q <= id_use_imm;
        end
    end

    assign alu_op1    = rs_fwd;
    assign alu_op2    = use_imm_q ? imm_q : rt_fwd;
    assign alu_cmd    = cmd_q;
    assign ex_valid   = valid_q;
    assign ex_rd_addr = rd_addr_q;
    assign ex_wr_en   = wr_en_q;
    assign ex_is_load = is_load_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Scoreboard bench for idex_operand_stage: directed scenarios then random traffic,
// checked against an instruction-level model of the EX slot.
module tb_idex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_cmd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_wr_en, id_is_load;
    logic        exmem_wr_en, memwb_wr_en;
    logic [2:0]  exmem_rd_addr, memwb_rd_addr;
    logic [15:0] exmem_res, memwb_data;
    logic [15:0] alu_op1, alu_op2;
    logic [2:0]  alu_cmd, ex_rd_addr;
    logic        ex_valid, ex_wr_en, ex_is_load, load_use_hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_cmd(id_cmd), .id_rd_addr(id_rd_addr),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .exmem_wr_en(exmem_wr_en), .exmem_rd_addr(exmem_rd_addr), .exmem_res(exmem_res),
        .memwb_wr_en(memwb_wr_en), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cmd(alu_cmd), .ex_valid(ex_valid),
        .ex_rd_addr(ex_rd_addr), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .load_use_hazard(load_use_hazard)
    );

    // The instruction currently sitting in EX, in architectural terms.
    typedef struct {
        bit        valid, wr, load, use_imm;
        bit [2:0]  rd, cmd, rs, rt;
        bit [15:0] rs_val, rt_val, imm;
    } ex_t;

    typedef struct {
        bit [15:0] op1, op2;
        bit [2:0]  cmd, rd;
        bit        valid, wr, load, haz;
    } exp_t;

    ex_t  m;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Value a reader of register r sees this cycle: newest in-flight write, else what was read.
    function automatic bit [15:0] newest(input bit [2:0] r, input bit [15:0] held);
        if (r == 0) return 16'h0;
        if (exmem_wr_en && exmem_rd_addr == r) return exmem_res;
        if (memwb_wr_en && memwb_rd_addr == r) return memwb_data;
        return held;
    endfunction

    function automatic bit model_hazard();
        bit reads_rd;
        reads_rd = (id_rs_addr == m.rd) || (!id_use_imm && id_rt_addr == m.rd);
        return id_valid && m.valid && m.load && (m.rd != 0) && reads_rd;
    endfunction

    function automatic ex_t take_id();
        ex_t c;
        c.valid   = id_valid;
        c.wr      = id_valid && id_wr_en;
        c.load    = id_valid && id_is_load;
        c.use_imm = id_use_imm;
        c.rd      = id_rd_addr;
        c.cmd     = id_cmd;
        c.rs      = id_rs_addr;
        c.rt      = id_rt_addr;
        c.rs_val  = (id_rs_addr == 0) ? 16'h0 : id_rs_data;
        c.rt_val  = (id_rt_addr == 0) ? 16'h0 : id_rt_data;
        c.imm     = id_imm;
        return c;
    endfunction

    task automatic model_reset();
        m = '{default: 0};
    endtask

    // Advance the model across a clock edge using the inputs held over that edge.
    task automatic tick();
        bit haz;
        @(posedge clk);
        #1;
        haz = model_hazard();
        if (!rst_n) begin
            model_reset();
        end else if (flush || (!stall && haz)) begin
            m = take_id();
            m.valid = 0; m.wr = 0; m.load = 0;
        end else if (stall) begin
            m.rs_val = newest(m.rs, m.rs_val);
            m.rt_val = newest(m.rt, m.rt_val);
        end else begin
            m = take_id();
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.op1   = newest(m.rs, m.rs_val);
        e.op2   = m.use_imm ? m.imm : newest(m.rt, m.rt_val);
        e.cmd   = m.cmd;
        e.rd    = m.rd;
        e.valid = m.valid;
        e.wr    = m.wr;
        e.load  = m.load;
        e.haz   = model_hazard();
        exp_q.push_back(e);
    endtask

    task automatic idle();
        stall = 0; flush = 0;
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_use_imm = 0; id_cmd = 0; id_rd_addr = 0; id_wr_en = 0; id_is_load = 0;
        exmem_wr_en = 0; exmem_rd_addr = 0; exmem_res = 0;
        memwb_wr_en = 0; memwb_rd_addr = 0; memwb_data = 0;
    endtask

    task automatic set_id(input bit [2:0] rs, input bit [2:0] rt, input bit [15:0] rsd,
                          input bit [15:0] rtd, input bit use_imm, input bit [15:0] imm,
                          input bit [2:0] cmd, input bit [2:0] rd, input bit wr, input bit ld);
        id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd; id_rt_data = rtd;
        id_use_imm = use_imm; id_imm = imm; id_cmd = cmd; id_rd_addr = rd;
        id_wr_en = wr; id_is_load = ld;
    endtask

    task automatic set_fwd(input bit ew, input bit [2:0] ea, input bit [15:0] ed,
                           input bit mw, input bit [2:0] ma, input bit [15:0] md);
        exmem_wr_en = ew; exmem_rd_addr = ea; exmem_res = ed;
        memwb_wr_en = mw; memwb_rd_addr = ma; memwb_data = md;
    endtask

    function automatic bit [2:0] rnd_reg();
        return ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
    endfunction

    // Monitor: the stage presents a result every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("alu_op1", 32'(alu_op1), 32'(e.op1));
                check("alu_op2", 32'(alu_op2), 32'(e.op2));
                check("alu_cmd", 32'(alu_cmd), 32'(e.cmd));
                check("ex_valid", 32'(ex_valid), 32'(e.valid));
                check("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
                check("ex_wr_en", 32'(ex_wr_en), 32'(e.wr));
                check("ex_is_load", 32'(ex_is_load), 32'(e.load));
                check("load_use_hazard", 32'(load_use_hazard), 32'(e.haz));
            end
        end
    end

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) begin tick(); push_exp(); end
        rst_n = 1;

        // Pass-through: SUB r5 <- r1, r2
        tick(); set_id(3'd1, 3'd2, 16'h0005, 16'h0003, 0, 16'h0, 3'b001, 3'd5, 1, 0); push_exp();
        tick(); idle(); push_exp();

        // Forwarding priority on rs = r2, then r0 guard
        tick(); set_id(3'd2, 3'd6, 16'h00AA, 16'h00BB, 0, 16'h0, 3'b000, 3'd7, 1, 0); push_exp();
        tick(); set_fwd(1, 3'd2, 16'h1111, 1, 3'd2, 16'h2222); push_exp();
        tick(); exmem_wr_en = 0; push_exp();
        tick(); set_id(3'd0, 3'd0, 16'h7777, 16'h8888, 0, 16'h0, 3'b110, 3'd1, 1, 0);
        set_fwd(1, 3'd0, 16'h1111, 1, 3'd0, 16'h2222); push_exp();
        tick(); push_exp();

        // Load-use on rt, then immediate form that must not stall
        tick(); idle(); set_id(3'd1, 3'd2, 16'h0010, 16'h0020, 0, 16'h0, 3'b000, 3'd3, 1, 1); push_exp();
        tick(); set_id(3'd1, 3'd3, 16'h0011, 16'h0022, 0, 16'h0, 3'b001, 3'd4, 1, 0); push_exp();
        tick(); push_exp();
        tick(); set_id(3'd1, 3'd2, 16'h0010, 16'h0020, 0, 16'h0, 3'b000, 3'd3, 1, 1); push_exp();
        tick(); set_id(3'd1, 3'd3, 16'h0011, 16'h0022, 1, 16'h0042, 3'b101, 3'd4, 1, 0); push_exp();
        tick(); idle(); push_exp();

        // Stall refresh keeps a MEM/WB value that retires during the stall
        tick(); set_id(3'd4, 3'd5, 16'h0004, 16'h0005, 0, 16'h0, 3'b010, 3'd6, 1, 0); push_exp();
        tick(); set_id(3'd1, 3'd1, 16'h0101, 16'h0101, 0, 16'h0, 3'b011, 3'd2, 1, 0);
        stall = 1; set_fwd(0, 3'd0, 16'h0, 1, 3'd4, 16'hBEEF); push_exp();
        tick(); memwb_wr_en = 0; push_exp();
        tick(); push_exp();
        tick(); stall = 0; push_exp();
        tick(); idle(); push_exp();

        // Flush and stall together insert a bubble
        tick(); set_id(3'd1, 3'd2, 16'h1234, 16'h5678, 0, 16'h0, 3'b111, 3'd5, 1, 1);
        flush = 1; stall = 1; push_exp();
        tick(); idle(); push_exp();

        // Reset asserted mid-stream with a valid instruction presented
        tick(); set_id(3'd3, 3'd4, 16'hAAAA, 16'h5555, 0, 16'h0, 3'b100, 3'd2, 1, 0); push_exp();
        tick(); rst_n = 0; model_reset(); push_exp();
        tick(); push_exp();
        tick(); rst_n = 1; push_exp();
        tick(); push_exp();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst_n       = ($urandom_range(0, 199) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            id_rs_addr  = rnd_reg();
            id_rt_addr  = rnd_reg();
            id_rd_addr  = rnd_reg();
            id_rs_data  = 16'($urandom);
            id_rt_data  = 16'($urandom);
            id_imm      = 16'($urandom);
            id_use_imm  = ($urandom_range(0, 2) == 0);
            id_cmd      = 3'($urandom_range(0, 7));
            id_wr_en    = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            set_fwd($urandom_range(0, 1) == 1, rnd_reg(), 16'($urandom),
                    $urandom_range(0, 1) == 1, rnd_reg(), 16'($urandom));
            if (!rst_n) model_reset();
            push_exp();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
